// File: rtl/tatsujin_pkg.sv
// Shared types for the note-lane game: sequencer states, lane bit positions
// and the 3-lane slice carried from the song ROM to the lane shifters.
package tatsujin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNTDOWN,
        ST_PLAY,
        ST_FLUSH,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam int LANE_RED    = 2;
    localparam int LANE_YELLOW = 1;
    localparam int LANE_BLUE   = 0;

    typedef logic [2:0] slice_t;

endpackage

// File: rtl/beat_divider.sv
// Beat divider: counts 0..BEAT_DIV-1 while enabled, holds when disabled,
// and flags the wrap cycle as the beat tick.
module beat_divider #(
    parameter int BEAT_DIV = 2_500_000,
    parameter int CNT_W    = $clog2(BEAT_DIV)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick_o  = en_i && (count_q == CNT_W'(BEAT_DIV - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i || tick_o) count_d = '0;
        else if (en_i)       count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) count_q <= '0;
        else          count_q <= count_d;
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: countdown, then one ROM slice shifted into the lanes per
// beat, then VIEW empty shifts to flush the visible window before DONE.
module song_sequencer
    import tatsujin_pkg::*;
#(
    parameter int SONG_LEN        = 100,
    parameter int BEAT_DIV        = 2_500_000,
    parameter int COUNTDOWN_BEATS = 4,
    parameter int VIEW            = 26,
    parameter int ADDR_W          = $clog2(SONG_LEN)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              pause_toggle,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  slice_t            rom_data,
    output logic              shift_en,
    output slice_t            note_in,
    output logic              clear_lanes,
    output logic              beat_tick,
    output logic [2:0]        countdown,
    output logic              busy,
    output logic              paused,
    output logic              done
);

    localparam int FLUSH_W = $clog2(VIEW + 1);
    localparam int DIV_W   = $clog2(BEAT_DIV);

    state_e               state_q, state_d, ret_q, ret_d, tgt;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [2:0]           cd_q, cd_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic                 shift_q, shift_d, clear_q, clear_d;
    slice_t               note_q, note_d;
    logic                 tick, div_en, div_clr;
    logic [DIV_W-1:0]     div_cnt_unused;

    assign div_en  = state_q inside {ST_COUNTDOWN, ST_PLAY, ST_FLUSH};
    assign div_clr = state_q inside {ST_IDLE, ST_DONE};

    beat_divider #(.BEAT_DIV(BEAT_DIV), .CNT_W(DIV_W)) u_div (
        .clk     (clk),
        .reset_b (reset_b),
        .en_i    (div_en),
        .clr_i   (div_clr),
        .count_o (div_cnt_unused),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        addr_d  = addr_q;
        cd_d    = cd_q;
        flush_d = flush_q;
        shift_d = 1'b0;
        note_d  = '0;
        clear_d = 1'b0;
        tgt     = state_q;
        if (abort) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
            addr_d  = '0;
            cd_d    = '0;
            flush_d = '0;
        end else begin
            if (tick) begin
                case (state_q)
                    ST_COUNTDOWN: begin
                        if (cd_q <= 3'd1) begin
                            tgt  = ST_PLAY;
                            cd_d = '0;
                        end else begin
                            cd_d = cd_q - 3'd1;
                        end
                    end
                    ST_PLAY: begin
                        shift_d = 1'b1;
                        note_d  = rom_data;
                        if (addr_q == ADDR_W'(SONG_LEN - 1)) tgt = ST_FLUSH;
                        else                                 addr_d = addr_q + 1'b1;
                    end
                    ST_FLUSH: begin
                        shift_d = 1'b1;
                        if (flush_q >= FLUSH_W'(VIEW - 1)) begin
                            tgt     = ST_DONE;
                            flush_d = FLUSH_W'(VIEW);
                        end else begin
                            flush_d = flush_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            state_d = tgt;
            // A toggle on a tick cycle pauses into wherever the tick leads.
            if (pause_toggle) begin
                if (state_q == ST_PAUSE) begin
                    state_d = ret_q;
                end else if (tgt inside {ST_COUNTDOWN, ST_PLAY, ST_FLUSH}) begin
                    state_d = ST_PAUSE;
                    ret_d   = tgt;
                end
            end
            if (start && (state_q inside {ST_IDLE, ST_DONE})) begin
                state_d = ST_COUNTDOWN;
                cd_d    = 3'(COUNTDOWN_BEATS);
                addr_d  = '0;
                flush_d = '0;
                clear_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            addr_q  <= '0;
            cd_q    <= '0;
            flush_q <= '0;
            shift_q <= 1'b0;
            note_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            addr_q  <= addr_d;
            cd_q    <= cd_d;
            flush_q <= flush_d;
            shift_q <= shift_d;
            note_q  <= note_d;
            clear_q <= clear_d;
        end
    end

    assign rom_addr    = addr_q;
    assign shift_en    = shift_q;
    assign note_in     = note_q;
    assign clear_lanes = clear_q;
    assign beat_tick   = tick;
    assign countdown   = cd_q;
    assign busy        = state_q inside {ST_COUNTDOWN, ST_PLAY, ST_FLUSH, ST_PAUSE};
    assign paused      = (state_q == ST_PAUSE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Controller that sequences the note-lane shifter through a complete song. It runs a countdown and then, once per beat, fetches one 3-lane note slice from the song ROM. It issues a one-cycle shift strobe carrying that slice into the tail of the red/yellow/blue lane registers. After the last slice it flushes the visible window with empty slices and raises `done`. It sits between the song ROM, the lane shift registers, and the renderer/score logic, replacing the free-running slow-clock shift.

## Interface

Parameters:

- `SONG_LEN`, 100: number of note slices in the song ROM (≥2).
- `BEAT_DIV`, 2_500_000: `clk` cycles per beat (≥2).
- `COUNTDOWN_BEATS`, 4: beats before the first fetch (1..7).
- `VIEW`, 26: flush shifts after the last slice; equals the visible lane depth.
- `ADDR_W`, `$clog2(SONG_LEN)`: ROM address width.

Ports:

- `clk` in 1: system clock.
- `reset_b` in 1: reset; one clock, asynchronous, active-low.
- `start` in 1: pulse; begins a song from IDLE or DONE.
- `pause_toggle` in 1: pulse; enters or leaves PAUSE.
- `abort` in 1: pulse; returns to IDLE from any state.
- `rom_addr` out ADDR_W: current slice address; registered.
- `rom_data` in 3: slice `{red, yellow, blue}`; valid one cycle after `rom_addr` changes.
- `shift_en` out 1: one-cycle shift strobe to the lane registers.
- `note_in` out 3: tail bits for the strobe `{red, yellow, blue}`; zero when `shift_en`=0.
- `clear_lanes` out 1: one-cycle pulse that zeroes the lane registers.
- `beat_tick` out 1: one-cycle pulse per beat (metronome/draw sync).
- `countdown` out 3: remaining countdown beats.
- `busy` out 1: high in COUNTDOWN, PLAY, PAUSE, FLUSH.
- `paused` out 1: high in PAUSE.
- `done` out 1: high in DONE.

## Operation

- States:
  - IDLE, COUNTDOWN, PLAY, FLUSH, PAUSE, DONE.
  - PAUSE stores its return state.
- Reset:
  - State is IDLE.
  - Every output is 0, including `rom_addr`, `countdown` and the beat divider.
- Beat divider:
  - Counts 0..`BEAT_DIV`-1 only in COUNTDOWN, PLAY and FLUSH.
  - Frozen (value held) in PAUSE; cleared in IDLE and DONE.
  - `beat_tick` asserts on the wrap cycle.
- IDLE/DONE + `start`:
  - Next state COUNTDOWN; `countdown`=`COUNTDOWN_BEATS`.
  - `rom_addr`=0, `done`=0, divider=0.
  - `clear_lanes` pulses in the following cycle.
- COUNTDOWN:
  - Each tick decrements `countdown`.
  - The tick taken with `countdown`=1 moves to PLAY with `countdown`=0.
- PLAY, on each tick:
  - Cycle after the tick: `shift_en`=1 and `note_in`=`rom_data` as sampled at the tick edge.
  - `rom_addr` increments in that same cycle.
  - When the slice at address `SONG_LEN`-1 is shifted, `rom_addr` holds and the state becomes FLUSH.
- FLUSH:
  - Each tick produces a shift with `note_in`=0.
  - After `VIEW` such shifts the state becomes DONE.
- `pause_toggle`:
  - COUNTDOWN/PLAY/FLUSH → PAUSE.
  - PAUSE → stored state.
  - Ignored in IDLE and DONE.
- Priority:
  - `abort` > tick processing > `pause_toggle` > `start`.
  - `start` is ignored outside IDLE/DONE.
- `abort`:
  - Any state → IDLE next cycle.
  - `clear_lanes` pulses; any pending shift is suppressed.
  - `rom_addr`=0 and `countdown`=0.
- Counters saturate and never wrap. The flush counter width is `$clog2(VIEW+1)`.

## Timing

- Strobe latency: a tick at edge T gives `shift_en` at cycle T+1, exactly one cycle wide.
- ROM fetch: `rom_addr` is stable for a whole beat (≥2 cycles), so `rom_data` is always settled at the tick.
- Tick and `pause_toggle` in the same cycle: the tick is processed and the shift strobe still fires next cycle. PAUSE is entered simultaneously.
- After resume: the first tick arrives `BEAT_DIV` − (divider value held at pause) cycles later.
- Shift count per song: exactly `SONG_LEN`+`VIEW` strobes from `start` to `done`.
- `done` is a level; it stays high until `start`, `abort` or reset.

## Structure

- Shared package `tatsujin_pkg` holds:
  - the state enum;
  - lane bit indices (`LANE_RED`=2, `LANE_YELLOW`=1, `LANE_BLUE`=0);
  - the slice type (3 bits).
- One sub-module, `beat_divider`:
  - Inputs: enable, synchronous clear.
  - Outputs: held count and a wrap tick.
  - Parameterised by `BEAT_DIV`.
- The FSM, address counter, flush counter and strobe register live in `song_sequencer`.

## Test plan

Bench parameters: `SONG_LEN`=4, `BEAT_DIV`=4, `COUNTDOWN_BEATS`=2, `VIEW`=3, ROM={101,010,001,100}.

- Reset mid-song, release → all outputs 0, state IDLE, no `shift_en` for 20 cycles.
- `start` at cycle 0 → `clear_lanes` at cycle 1, `countdown` 2→1→0, then 7 strobes spaced 4 cycles with `note_in`=101,010,001,100,000,000,000, then `done`=1.
- `pause_toggle` 1 cycle after a strobe in PLAY, held paused 10 cycles, `pause_toggle` again → no strobe while paused; next strobe 3 cycles after resume; `note_in` sequence intact.
- `pause_toggle` on a tick cycle → strobe still at T+1; `paused`=1 from T+1; no further strobes until resume.
- `abort` during FLUSH after 1 zero-shift → IDLE next cycle, `clear_lanes`=1 once, `rom_addr`=0, no further strobes, `done`=0.
- `start` during PLAY → ignored; `start` from DONE → `rom_addr`=0, countdown restarts, full 7-strobe sequence repeats.
